approx_add_pipe: RTL and testbench
==================================

# approx_add_pipe

Parametrised, pipelined unsigned adder with run-time-selectable low-part approximation. It is the next generation of our fixed 8-bit approximate adders: operand width, carry-segment size and approximation depth are all configurable, and a valid/ready stream interface makes it drop-in for streaming FPGA datapaths. It sits between operand producers (filters, MAC trees) and consumers tolerant of bounded arithmetic error.

## Interface
Parameters:
- W, 8: operand width in bits (≥ 2).
- SEG, 4: carry-chain segment width per pipeline stage (1..W). NSEG = ceil(W/SEG) stages; the last segment may be partial.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  W  operand A, unsigned.
- in_b  in  W  operand B, unsigned.
- in_mode  in  2  0 = EXACT, 1 = LOA, 2 = TRUNC, 3 = reserved (behaves as EXACT).
- in_k  in  clog2(W+1)  number of approximated low bits.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W+1  result, carry-out in bit W.

## Operation
- Mode and k are sampled with the operands on acceptance and travel with the beat. Changing in_mode/in_k never affects beats already in flight.
- Effective k: ke = min(in_k, W-1). ke = 0 or EXACT/reserved mode gives the exact sum A+B.
- LOA, bits i < ke: out_sum[i] = A[i] | B[i]. Carry into bit ke = A[ke-1] & B[ke-1].
- TRUNC, bits i < ke: out_sum[i] = 1 for i = ke-1, else 0. Carry into bit ke = A[ke-1] & B[ke-1].
- Bits ke..W: exact addition of A[W-1:ke] + B[W-1:ke] + injected carry. Carry-out lands in out_sum[W].
- Permitted implementation of the carry injection:
  - Zero a and b below bit ke.
  - Set bit ke-1 of both to c.
  - Add the two values, then overwrite bits < ke with the forced pattern.
- Pipeline structure:
  - Stage s (0..NSEG-1) adds segment s bits with the registered carry from stage s-1.
  - Each stage registers the segment's sum bits, the carry, the remaining higher operand bits and the forced low-bit pattern.
  - Already-computed low segments are delayed alongside.
- Flow control is a single global advance: adv = !v[NSEG-1] | out_ready.
  - in_ready = adv, combinational.
  - Every stage register, including the valid bits v[], loads only when adv = 1.
  - Input accepted iff in_valid & in_ready.
  - v[0] loads in_valid & adv.
- Bubbles are not compressed; a stalled pipeline holds all stages.
- out_valid = v[NSEG-1]; out_sum = last-stage sum register.

## Timing
- Latency: a beat accepted at edge t appears on out_valid/out_sum after edge t+NSEG-1. This gives NSEG cycles of register latency, including the input-capturing stage.
- Throughput: one beat per cycle while out_ready = 1.
- Reset (asynchronous assert): all v[] = 0, all data registers = 0, out_valid = 0, out_sum = 0. in_ready = 1 while reset is held (since !v[NSEG-1]).
- Reset released mid-stream: every in-flight beat is discarded, with no partial output. First acceptance is possible on the first clk edge after deassertion.
- out_ready = 0 with out_valid = 1:
  - out_sum and out_valid hold stable.
  - in_ready = 0, so no acceptance.
  - Stalls for any number of cycles without loss or duplication.
- out_valid = 0: in_ready = 1 regardless of out_ready, so an empty or draining pipeline always fills.
- Simultaneous out_ready and in_valid with a full pipeline: output is consumed and input accepted in the same cycle.
- Overflow: A+B up to 2^(W+1)-2 fits in out_sum. Approximation never exceeds 2^(W+1)-1.

## Test plan
- W=8, SEG=4, EXACT: A=200, B=100 accepted at edge 0 -> out_sum = 300 (0x12C) valid after edge 1.
- LOA, k=4: A=0x1F, B=0x0B -> out_sum = 0x02F (47; exact 42).
- TRUNC, k=4: A=0xFF, B=0xFF -> out_sum = 0x1F8 (504; exact 510).
- TRUNC, k=15 (clamped to 7): A=0x80, B=0x80 -> out_sum = 0x140. Also in_mode=3, A=B=0xFF -> 0x1FE.
- Back-to-back stream of 10 random beats with out_ready = 0 for 3 cycles mid-stream:
  - in_ready drops in the same cycle.
  - Output sequence equals the reference-model sequence, with no loss or duplication.
  - Mode/k changes per beat are honoured per beat.
- Assert rst_n low with 2 beats in flight -> out_valid = 0 and out_sum = 0 immediately. No stale beat after release. A new beat returns the correct result NSEG cycles later.

Source files
------------

// File: rtl/approx_add_pipe.sv
// Pipelined unsigned adder with per-beat selectable low-part approximation (LOA / truncation).
// One carry segment per stage; a single global advance stalls every stage together.
module approx_add_pipe #(
  parameter int unsigned W   = 8,
  parameter int unsigned SEG = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  input  logic [1:0]             in_mode,
  input  logic [$clog2(W+1)-1:0] in_k,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W:0]             out_sum
);

  localparam int unsigned NSEG = (W + SEG - 1) / SEG;

  typedef enum logic [1:0] {
    ModeExact = 2'd0,
    ModeLoa   = 2'd1,
    ModeTrunc = 2'd2,
    ModeRsvd  = 2'd3
  } mode_e;

  logic              adv;
  logic              approx;
  logic              c_inj;
  int unsigned       ke_i;
  logic [W-1:0]      pa, pb, force_lo;

  logic [NSEG-1:0]   v_q, v_d;
  logic              c_q   [NSEG];
  logic              c_d   [NSEG];
  logic [W-1:0]      a_q   [NSEG];
  logic [W-1:0]      a_d   [NSEG];
  logic [W-1:0]      b_q   [NSEG];
  logic [W-1:0]      b_d   [NSEG];
  logic [W-1:0]      lo_q  [NSEG];
  logic [W-1:0]      lo_d  [NSEG];
  logic [W:0]        sum_q [NSEG];
  logic [W:0]        sum_d [NSEG];

  assign adv       = !v_q[NSEG-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[NSEG-1];
  assign out_sum   = sum_q[NSEG-1];

  // Operand conditioning: bits below ke are cleared, bit ke-1 of both operands carries c_inj so
  // the exact adder produces 0 there and ripples c_inj into bit ke.
  always_comb begin
    ke_i     = (32'(in_k) > W - 1) ? W - 1 : 32'(in_k);
    approx   = ((in_mode == ModeLoa) || (in_mode == ModeTrunc)) && (ke_i != 0);
    c_inj    = 1'b0;
    pa       = in_a;
    pb       = in_b;
    force_lo = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (approx && (i < ke_i)) begin
        pa[i] = 1'b0;
        pb[i] = 1'b0;
        if (i == ke_i - 1) begin
          c_inj = in_a[i] & in_b[i];
          pa[i] = c_inj;
          pb[i] = c_inj;
        end
        force_lo[i] = (in_mode == ModeLoa) ? (in_a[i] | in_b[i]) : (i == ke_i - 1);
      end
    end
  end

  always_comb begin : p_stages
    logic        carry;
    logic [W-1:0] a_t, b_t, lo_t;
    logic [W:0]   s_t;
    int unsigned  prev;
    for (int unsigned s = 0; s < NSEG; s++) begin
      prev   = (s == 0) ? 0 : s - 1;
      carry  = (s == 0) ? 1'b0 : c_q[prev];
      a_t    = (s == 0) ? pa : a_q[prev];
      b_t    = (s == 0) ? pb : b_q[prev];
      lo_t   = (s == 0) ? force_lo : lo_q[prev];
      s_t    = (s == 0) ? '0 : sum_q[prev];
      v_d[s] = (s == 0) ? in_valid : v_q[prev];
      for (int unsigned i = 0; i < W; i++) begin
        if (i / SEG == s) begin
          s_t[i] = a_t[i] ^ b_t[i] ^ carry;
          carry  = (a_t[i] & b_t[i]) | (carry & (a_t[i] | b_t[i]));
        end
      end
      // Low bits of the exact sum are zero below ke, so OR-ing applies the forced pattern.
      if (s == NSEG - 1) begin
        s_t[W]     = carry;
        s_t[W-1:0] = s_t[W-1:0] | lo_t;
      end
      sum_d[s] = s_t;
      c_d[s]   = carry;
      a_d[s]   = a_t;
      b_d[s]   = b_t;
      lo_d[s]  = lo_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int unsigned s = 0; s < NSEG; s++) begin
        c_q[s]   <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        lo_q[s]  <= '0;
        sum_q[s] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      for (int unsigned s = 0; s < NSEG; s++) begin
        c_q[s]   <= c_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        lo_q[s]  <= lo_d[s];
        sum_q[s] <= sum_d[s];
      end
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe: directed test-plan vectors, randomized streams with
// stalls against an arithmetic reference model, and asynchronous reset with beats in flight.
module tb_approx_add_pipe;

  localparam int unsigned W    = 8;
  localparam int unsigned SEG  = 4;
  localparam int unsigned NSEG = (W + SEG - 1) / SEG;
  localparam int unsigned KW   = $clog2(W + 1);
  localparam int          WO   = W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [1:0]    in_mode = '0;
  logic [KW-1:0] in_k = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W:0]    out_sum;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  approx_add_pipe #(.W(W), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  // Arithmetic reference: exact upper part plus injected carry, forced low pattern.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] m, input int k);
    int ke, c, hi, lo;
    ke = k;
    if (ke > W - 1) ke = W - 1;
    if (m == 2'd0 || m == 2'd3 || ke == 0) return WO'(int'(a) + int'(b));
    c  = int'(a[ke-1] & b[ke-1]);
    hi = ((int'(a) >> ke) + (int'(b) >> ke) + c) << ke;
    if (m == 2'd1) lo = (int'(a) | int'(b)) & ((1 << ke) - 1);
    else           lo = 1 << (ke - 1);
    return WO'(hi | lo);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (out_sum !== '0) begin
      miscompares++;
      $display("FAIL reset_out_sum: got %h want 000", out_sum);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] m, input logic [KW-1:0] k,
                               input logic [W:0] exp);
    @(negedge clk);
    out_ready = 1'b1;
    in_a = a; in_b = b; in_mode = m; in_k = k; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    @(negedge clk);
    // Scramble inputs after acceptance; the in-flight beat must be unaffected.
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    in_mode = 2'($urandom_range(0, 3)); in_k = KW'($urandom_range(0, 15));
    for (int i = 1; i < NSEG; i++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_early_valid: got %b want 0", name, out_valid);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid: got %b want 1", name, out_valid);
    end
    vectors++;
    if (out_sum !== exp) begin
      miscompares++;
      $display("FAIL %s_sum: got %h want %h", name, out_sum, exp);
    end
  endtask

  // Pipeline occupancy modelled as NSEG slots that shift whenever the output may move.
  task automatic test_stream(input string name, input int nbeats, input bit rnd_flow);
    logic       m_v [NSEG];
    logic [W:0] m_s [NSEG];
    logic       exp_ready;
    int sent = 0, dut_got = 0, cyc = 0;
    for (int s = 0; s < NSEG; s++) begin
      m_v[s] = 1'b0;
      m_s[s] = '0;
    end
    while ((sent < nbeats || dut_got < nbeats) && cyc < 300) begin
      @(negedge clk);
      out_ready = rnd_flow ? ($urandom_range(0, 3) != 0) : !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < nbeats) && (!rnd_flow || ($urandom_range(0, 3) != 0));
      in_a = W'($urandom); in_b = W'($urandom);
      in_mode = 2'($urandom_range(0, 3)); in_k = KW'($urandom_range(0, 15));
      #1;
      exp_ready = !m_v[NSEG-1] || out_ready;
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL %s_in_ready cyc %0d: got %b want %b", name, cyc, in_ready, exp_ready);
      end
      vectors++;
      if (out_valid !== m_v[NSEG-1]) begin
        miscompares++;
        $display("FAIL %s_out_valid cyc %0d: got %b want %b", name, cyc, out_valid,
                 m_v[NSEG-1]);
      end
      if (m_v[NSEG-1]) begin
        vectors++;
        if (out_sum !== m_s[NSEG-1]) begin
          miscompares++;
          $display("FAIL %s_sum cyc %0d: got %h want %h", name, cyc, out_sum, m_s[NSEG-1]);
        end
      end
      if (out_valid === 1'b1 && out_ready) dut_got++;
      if (exp_ready) begin
        for (int s = NSEG - 1; s > 0; s--) begin
          m_v[s] = m_v[s-1];
          m_s[s] = m_s[s-1];
        end
        m_v[0] = in_valid;
        m_s[0] = ref_sum(in_a, in_b, in_mode, int'(in_k));
        if (in_valid) sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (dut_got != nbeats || sent != nbeats) begin
      miscompares++;
      $display("FAIL %s_count: got %0d out / %0d in, want %0d", name, dut_got, sent, nbeats);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A; in_mode = 2'd1; in_k = 4'd3;
    @(negedge clk);
    in_a = 8'h33; in_b = 8'hC4; in_mode = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre_valid: got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (out_sum !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_sum: got %h want 000", out_sum);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_stale cyc %0d: got %b want 0", i, out_valid);
      end
    end
    test_directed("post_reset", 8'd77, 8'd99, 2'd2, 4'd2, 9'h0AE);
  endtask

  initial begin
    test_reset();
    test_directed("exact", 8'd200, 8'd100, 2'd0, 4'd0, 9'h12C);
    test_directed("loa_k4", 8'h1F, 8'h0B, 2'd1, 4'd4, 9'h02F);
    test_directed("trunc_k4", 8'hFF, 8'hFF, 2'd2, 4'd4, 9'h1F8);
    test_directed("trunc_k15", 8'h80, 8'h80, 2'd2, 4'd15, 9'h140);
    test_directed("reserved", 8'hFF, 8'hFF, 2'd3, 4'd5, 9'h1FE);
    test_directed("loa_k7", 8'hF0, 8'h0F, 2'd1, 4'd7, 9'h0FF);
    test_stream("back_to_back", 10, 1'b0);
    test_stream("random_flow", 40, 1'b1);
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
